// File: rtl/airlock_pkg.sv
// Shared state encoding and defaults for the airlock sequencer.
// Bit 4 of the state code is the departure flag and bits 3:0 are the step number.
package airlock_pkg;

  localparam logic [15:0] TMO_DEFAULT = 16'd50000;

  // The 4-bit debug code is the step within a path (1..8). IDLE reads as 0
  // and FAULT reads as F. The dir output tells the arrival and departure paths apart.
  typedef enum logic [4:0] {
    IDLE       = 5'h00,
    A_FILL     = 5'h01,
    A_OPEN_O   = 5'h02,
    A_WAIT_IN  = 5'h03,
    A_CLOSE_O  = 5'h04,
    A_DRAIN    = 5'h05,
    A_OPEN_I   = 5'h06,
    A_WAIT_OUT = 5'h07,
    A_CLOSE_I  = 5'h08,
    FAULT      = 5'h0f,
    D_OPEN_I   = 5'h11,
    D_WAIT_IN  = 5'h12,
    D_CLOSE_I  = 5'h13,
    D_FILL     = 5'h14,
    D_OPEN_O   = 5'h15,
    D_WAIT_OUT = 5'h16,
    D_CLOSE_O  = 5'h17,
    D_DRAIN    = 5'h18
  } st_e;

  function automatic logic is_wait(input st_e s);
    return s inside {A_WAIT_IN, A_WAIT_OUT, D_WAIT_IN, D_WAIT_OUT};
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step cycle counter. It restarts on clr and saturates instead of wrapping.
// expired is high in the cycle where the count equals TMO-1.
module step_timer #(
  parameter logic [15:0] TMO = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (cnt != 16'hffff) cnt <= cnt + 16'd1;
  end

  assign expired = (cnt == TMO - 16'd1);

endmodule

// File: rtl/airlock_sequencer.sv
// Moore sequencer for a flooding airlock. It handles arrival and departure paths.
// A per-step timeout and a level-sensor contradiction both lead to a sticky FAULT.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter logic [15:0] TMO = TMO_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       appr,
  input  logic       dprt,
  input  logic       pres,
  input  logic       od_closed,
  input  logic       id_closed,
  input  logic       lvl_hi,
  input  logic       lvl_lo,
  output logic       DO,
  output logic       DI,
  output logic       fill,
  output logic       empty,
  output logic       busy,
  output logic       dir,
  output logic       fault,
  output logic [3:0] state
);

  st_e  st, nxt, tgt;
  logic ex, expired;

  step_timer #(.TMO(TMO)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (nxt != st),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= IDLE;
      dir <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && nxt != IDLE) dir <= (nxt == D_OPEN_I);
    end
  end

  always_comb begin
    ex  = 1'b0;
    tgt = st;
    nxt = st;
    case (st)
      A_FILL:     begin ex = lvl_hi;     tgt = A_OPEN_O;   end
      A_OPEN_O:   begin ex = ~od_closed; tgt = A_WAIT_IN;  end
      A_WAIT_IN:  begin ex = pres;       tgt = A_CLOSE_O;  end
      A_CLOSE_O:  begin ex = od_closed;  tgt = A_DRAIN;    end
      A_DRAIN:    begin ex = lvl_lo;     tgt = A_OPEN_I;   end
      A_OPEN_I:   begin ex = ~id_closed; tgt = A_WAIT_OUT; end
      A_WAIT_OUT: begin ex = ~pres;      tgt = A_CLOSE_I;  end
      A_CLOSE_I:  begin ex = id_closed;  tgt = IDLE;       end
      D_OPEN_I:   begin ex = ~id_closed; tgt = D_WAIT_IN;  end
      D_WAIT_IN:  begin ex = pres;       tgt = D_CLOSE_I;  end
      D_CLOSE_I:  begin ex = id_closed;  tgt = D_FILL;     end
      D_FILL:     begin ex = lvl_hi;     tgt = D_OPEN_O;   end
      D_OPEN_O:   begin ex = ~od_closed; tgt = D_WAIT_OUT; end
      D_WAIT_OUT: begin ex = ~pres;      tgt = D_CLOSE_O;  end
      D_CLOSE_O:  begin ex = od_closed;  tgt = D_DRAIN;    end
      D_DRAIN:    begin ex = lvl_lo;     tgt = IDLE;       end
      default:    ;
    endcase
    if (st == IDLE) begin
      if (dprt)      nxt = D_OPEN_I;
      else if (appr) nxt = A_FILL;
    end else if (st != FAULT) begin
      // Priority: a broken level sensor first, then progress, then the timeout.
      if (lvl_hi && lvl_lo)              nxt = FAULT;
      else if (ex)                       nxt = tgt;
      else if (expired && !is_wait(st)) nxt = FAULT;
    end
  end

  assign DO    = st inside {A_OPEN_O, A_WAIT_IN, D_OPEN_O, D_WAIT_OUT};
  assign DI    = st inside {A_OPEN_I, A_WAIT_OUT, D_OPEN_I, D_WAIT_IN};
  assign fill  = st inside {A_FILL, D_FILL};
  assign empty = st inside {A_DRAIN, D_DRAIN};
  assign busy  = (st != IDLE) && (st != FAULT);
  assign fault = (st == FAULT);
  assign state = st[3:0];

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer with TMO=8. A small plant answers commands after 3 cycles.
// A scoreboard queue holds the expected {dir,state} sequence for each full path.
module tb_airlock_sequencer;

  logic clk = 1'b0, rst = 1'b0, appr = 1'b0, dprt = 1'b0, pres = 1'b0;
  logic od_closed = 1'b1, id_closed = 1'b1, lvl_hi = 1'b0, lvl_lo = 1'b1;
  logic DO, DI, fill, empty, busy, dir, fault;
  logic [3:0] state;

  always #5 clk = ~clk;

  airlock_sequencer #(.TMO(16'd8)) dut (
    .clk(clk), .rst(rst), .appr(appr), .dprt(dprt), .pres(pres),
    .od_closed(od_closed), .id_closed(id_closed), .lvl_hi(lvl_hi), .lvl_lo(lvl_lo),
    .DO(DO), .DI(DI), .fill(fill), .empty(empty), .busy(busy), .dir(dir),
    .fault(fault), .state(state)
  );

  typedef struct {
    logic       appr, dprt;
    logic [4:0] ds;
    logic [4:0] cmd;   // {DO,DI,fill,empty,busy}
  } vec_t;

  int         nvec = 0, nerr = 0, ilk_err = 0, n;
  logic [4:0] sb_q[$];
  logic [4:0] prev, exp_ds;
  bit         sb_on = 0, plant_en = 0;
  int         od_cnt, id_cnt, oo_cnt, io_cnt, f_cnt, e_cnt;
  vec_t       tbl[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic plant_init();
    pres = 0; od_closed = 1; id_closed = 1; lvl_hi = 0; lvl_lo = 1;
    od_cnt = 0; id_cnt = 0; oo_cnt = 0; io_cnt = 0; f_cnt = 0; e_cnt = 0;
  endtask

  // One cycle: sample at the falling edge, score, then let the plant react.
  task automatic step();
    @(negedge clk);
    if ((DO && DI) || (fill && empty) || ((fill || empty) && (DO || DI))) ilk_err++;
    if (sb_on && {dir, state} !== prev) begin
      if (sb_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL sb_extra: got %0h expected no change", {dir, state});
      end else begin
        exp_ds = sb_q.pop_front();
        check("sb_state", {dir, state}, exp_ds);
      end
    end
    prev = {dir, state};
    if (plant_en) begin
      if (DO == od_closed) od_cnt++; else od_cnt = 0;
      if (od_cnt == 3) begin od_closed = ~od_closed; od_cnt = 0; end
      if (DI == id_closed) id_cnt++; else id_cnt = 0;
      if (id_cnt == 3) begin id_closed = ~id_closed; id_cnt = 0; end
      // The vessel moves through a door 3 cycles after that door opens.
      if (!od_closed) oo_cnt++; else oo_cnt = 0;
      if (!id_closed) io_cnt++; else io_cnt = 0;
      if (oo_cnt == 3 || io_cnt == 3) pres = ~pres;
      if (fill) f_cnt++; else f_cnt = 0;
      if (f_cnt == 3) begin lvl_hi = 1; lvl_lo = 0; f_cnt = 0; end
      if (empty) e_cnt++; else e_cnt = 0;
      if (e_cnt == 3) begin lvl_hi = 0; lvl_lo = 1; e_cnt = 0; end
    end
  endtask

  task automatic do_reset();
    plant_en = 0; sb_on = 0;
    @(negedge clk);
    rst = 0; appr = 0; dprt = 0;
    plant_init();
    repeat (2) @(negedge clk);
    rst = 1;
    prev = {dir, state};
  endtask

  task automatic run_path(input bit d, input bit both, input string nm);
    sb_q.delete();
    for (int k = 1; k <= 8; k++) sb_q.push_back({d, 4'(k)});
    sb_q.push_back({d, 4'h0});
    ilk_err = 0; plant_en = 1; sb_on = 1;
    prev = {dir, state};
    if (both) begin appr = 1; dprt = 1; end
    else if (d) dprt = 1;
    else appr = 1;
    step();
    appr = 0; dprt = 0;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin step(); n++; end
    check({nm, "_done"}, sb_q.size(), 0);
    check({nm, "_ilk"}, ilk_err, 0);
    check({nm, "_fault"}, fault, 0);
    sb_on = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{appr: 0, dprt: 0, ds: 5'h00, cmd: 5'b00000};
    tbl[1] = '{appr: 1, dprt: 0, ds: 5'h01, cmd: 5'b00101};
    tbl[2] = '{appr: 0, dprt: 1, ds: 5'h11, cmd: 5'b01001};
    tbl[3] = '{appr: 1, dprt: 1, ds: 5'h11, cmd: 5'b01001};

    // Reset state while rst is still low
    #2;
    check("rst_state", {dir, state}, 5'h00);
    check("rst_outs", {DO, DI, fill, empty, busy, fault}, 6'b0);

    // Request decode out of IDLE
    foreach (tbl[i]) begin
      do_reset();
      appr = tbl[i].appr; dprt = tbl[i].dprt;
      step();
      appr = 0; dprt = 0;
      check($sformatf("vec%0d_state", i), {dir, state}, tbl[i].ds);
      check($sformatf("vec%0d_cmd", i), {DO, DI, fill, empty, busy}, tbl[i].cmd);
      check($sformatf("vec%0d_fault", i), fault, 0);
    end

    // Full paths, each starting from a calm plant
    do_reset();
    run_path(0, 0, "arrival");
    run_path(1, 1, "depart_both");
    check("depart_dir_hold", dir, 1);
    run_path(0, 0, "arrival2");
    check("arrival_dir_hold", dir, 0);

    // Timeout in A_FILL, with a request held to show that it is ignored
    do_reset();
    appr = 1;
    step();
    appr = 0; dprt = 1;
    check("to_enter", {dir, state}, 5'h01);
    n = 1;
    while (state == 4'h1 && n < 40) begin step(); if (state == 4'h1) n++; end
    check("to_cycles", n, 8);
    check("to_state", state, 4'hf);
    check("to_outs", {DO, DI, fill, empty, busy, fault}, 6'b000001);
    repeat (20) step();
    check("to_sticky", {state, fault}, {4'hf, 1'b1});
    dprt = 0;
    do_reset();
    check("to_cleared", {state, fault}, 5'h00);

    // The exit condition wins when it arrives in the same cycle as the timeout
    do_reset();
    appr = 1;
    step();
    appr = 0;
    repeat (7) step();
    check("race_pre", {dir, state}, 5'h01);
    lvl_hi = 1; lvl_lo = 0;
    step();
    check("race_state", {dir, state}, 5'h02);
    check("race_fault", fault, 0);

    // Asynchronous reset during D_OPEN_O
    do_reset();
    plant_en = 1; dprt = 1;
    step();
    dprt = 0;
    n = 0;
    while ({dir, state} != 5'h15 && n < 200) begin step(); n++; end
    check("ar_reach", {dir, state}, 5'h15);
    check("ar_do_pre", DO, 1);
    #1 rst = 0;
    #1;
    check("ar_do_async", DO, 0);
    check("ar_state_async", {dir, state, busy}, 6'b0);
    plant_en = 0;
    plant_init();
    @(negedge clk);
    rst = 1;
    repeat (3) step();
    check("ar_after", {dir, state, busy}, 6'b0);

    // Level sensor contradiction during A_DRAIN
    do_reset();
    plant_en = 1; appr = 1;
    step();
    appr = 0;
    n = 0;
    while ({dir, state} != 5'h05 && n < 200) begin step(); n++; end
    check("sc_reach", {dir, state}, 5'h05);
    plant_en = 0;
    lvl_hi = 1; lvl_lo = 1;
    step();
    check("sc_fault", {state, fault}, {4'hf, 1'b1});
    check("sc_cmds", {DO, DI, fill, empty}, 4'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/airlock_sequencer.md
AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

Interface
REQ-001 Parameter TMO, default 16'd50000, step timeout in clk cycles, valid range 2..65535.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 appr  in  1  bathysphere outside requests entry, level-sampled.
REQ-005 dprt  in  1  bathysphere inside requests exit, level-sampled.
REQ-006 pres  in  1  1 = bathysphere inside chamber.
REQ-007 od_closed  in  1  1 = outer door fully closed.
REQ-008 id_closed  in  1  1 = inner door fully closed.
REQ-009 lvl_hi  in  1  1 = chamber at outside (flooded) level.
REQ-010 lvl_lo  in  1  1 = chamber drained.
REQ-011 DO  out  1  open-outer-door command; 0 commands close.
REQ-012 DI  out  1  open-inner-door command; 0 commands close.
REQ-013 fill  out  1  pump-in command.
REQ-014 empty  out  1  pump-out command.
REQ-015 busy  out  1  1 in every state except IDLE and FAULT.
REQ-016 dir  out  1  1 = departure sequence active; holds last value in IDLE.
REQ-017 fault  out  1  1 only in FAULT.
REQ-018 state  out  4  current state code, for LED debug.

Function
REQ-019 Moore FSM; all outputs SHALL decode from registered state only, so each output changes on the clock edge that enters a state.
REQ-020 States: IDLE, A_FILL, A_OPEN_O, A_WAIT_IN, A_CLOSE_O, A_DRAIN, A_OPEN_I, A_WAIT_OUT, A_CLOSE_I, D_OPEN_I, D_WAIT_IN, D_CLOSE_I, D_FILL, D_OPEN_O, D_WAIT_OUT, D_CLOSE_O, D_DRAIN, FAULT.
REQ-021 IDLE: dprt=1 -> D_OPEN_I with dir=1; else appr=1 -> A_FILL with dir=0; dprt wins when both are 1.
REQ-022 Requests SHALL be ignored outside IDLE; they are not latched.
REQ-023 Arrival path: A_FILL (fill=1) exits on lvl_hi; A_OPEN_O (DO=1) on ~od_closed; A_WAIT_IN (DO=1) on pres; A_CLOSE_O on od_closed; A_DRAIN (empty=1) on lvl_lo; A_OPEN_I (DI=1) on ~id_closed; A_WAIT_OUT (DI=1) on ~pres; A_CLOSE_I on id_closed -> IDLE.
REQ-024 Departure path: D_OPEN_I (DI=1) exits on ~id_closed; D_WAIT_IN (DI=1) on pres; D_CLOSE_I on id_closed; D_FILL (fill=1) on lvl_hi; D_OPEN_O (DO=1) on ~od_closed; D_WAIT_OUT (DO=1) on ~pres; D_CLOSE_O on od_closed; D_DRAIN (empty=1) on lvl_lo -> IDLE.
REQ-025 Interlocks: DO and DI never both 1; fill and empty never both 1; no pump command while any door is commanded open.
REQ-026 Step timer SHALL clear to 0 on every state change and increment each cycle otherwise.
REQ-027 Any busy state other than the four WAIT states SHALL enter FAULT when the timer reaches TMO-1 and its exit condition is still false.
REQ-028 WAIT states have no timeout.
REQ-029 When the exit condition and the timeout are both true in the same cycle, the exit condition wins.
REQ-030 FAULT: DO=DI=fill=empty=0 and fault=1; FAULT is left only by reset.
REQ-031 A sensor contradiction (lvl_hi & lvl_lo both 1) in any busy state SHALL enter FAULT on the next edge.

Reset
REQ-032 While rst=0: state=IDLE, timer=0, dir=0, and every output 0, asynchronously.
REQ-033 Reset mid-sequence SHALL drop all commands immediately; the sequence is not resumed.

Structure
REQ-034 airlock_pkg SHALL hold the state encoding and the TMO default.
REQ-035 Sub-module step_timer (16-bit counter with clr, expiry compare against TMO) SHALL be instantiated once.

Verification
REQ-036 Arrival, TMO=8, sensors respond in 3 cycles: appr=1 -> states visited in order A_FILL..A_CLOSE_I -> IDLE; fault stays 0; DO and DI never both 1.
REQ-037 Departure with appr=dprt=1 in IDLE -> D_OPEN_I entered, dir=1, and the full D path completes to IDLE.
REQ-038 A_FILL with lvl_hi held 0, TMO=8 -> FAULT on the 8th cycle in A_FILL, all commands 0, fault=1 held until rst.
REQ-039 lvl_hi asserted on the same cycle the timer reaches 7 (TMO=8) -> A_OPEN_O entered, no FAULT.
REQ-040 rst pulled low during D_OPEN_O -> DO=0 with no clock edge required; after release, state=IDLE.
REQ-041 lvl_hi=lvl_lo=1 during A_DRAIN -> FAULT on the next edge.
